// File: rtl/ant_move_pkg.sv
// Shared move codes, inverse-move helper and rewinder FSM states for the ant
// trail logic.
package ant_move_pkg;

  localparam int MOVE_W = 3;

  localparam logic [MOVE_W-1:0] MOVE_N  = 3'd0;
  localparam logic [MOVE_W-1:0] MOVE_NE = 3'd1;
  localparam logic [MOVE_W-1:0] MOVE_E  = 3'd2;
  localparam logic [MOVE_W-1:0] MOVE_SE = 3'd3;
  localparam logic [MOVE_W-1:0] MOVE_S  = 3'd4;
  localparam logic [MOVE_W-1:0] MOVE_SW = 3'd5;
  localparam logic [MOVE_W-1:0] MOVE_W_ = 3'd6;
  localparam logic [MOVE_W-1:0] MOVE_NW = 3'd7;

  typedef enum logic [1:0] {
    RECORD = 2'd0,
    RETURN = 2'd1,
    DONE   = 2'd2
  } trail_state_e;

  // Opposite compass direction: half a turn is +4 mod 8, which is a flip of the MSB.
  function automatic logic [MOVE_W-1:0] inv_move(input logic [MOVE_W-1:0] m);
    return m ^ 3'b100;
  endfunction

endpackage

// File: rtl/move_lifo.sv
// Move trail storage: S x W register array indexed by pointer, with depth,
// full and empty. Optional macro TRAIL_WRAP_EN turns the array into a
// circular buffer that overwrites the oldest move when full.
module move_lifo
  import ant_move_pkg::*;
#(
  parameter int W  = MOVE_W,
  parameter int S  = 32,
  parameter int DW = $clog2(S) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = (S > 1) ? $clog2(S) : 1;

  logic [S-1:0][W-1:0] mem_q, mem_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [AW-1:0]       wr_idx, rd_idx;

`ifdef TRAIL_WRAP_EN
  // Head is the next write slot; the oldest entry sits depth slots behind it.
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] head_inc, head_dec;

  // Modular head arithmetic so non-power-of-two depths also wrap correctly.
  always_comb begin
    head_inc = (head_q == AW'(S - 1)) ? '0 : head_q + AW'(1);
    head_dec = (head_q == '0) ? AW'(S - 1) : head_q - AW'(1);
    wr_idx   = head_q;
    rd_idx   = head_dec;
  end
`else
  // Without wrap the depth itself is the stack pointer; pushes stop at full.
  always_comb begin
    wr_idx = AW'(depth_q);
    rd_idx = AW'(depth_q - DW'(1));
  end
`endif

  // Next-state for storage, depth and pointer; push and pop never coincide.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
`ifdef TRAIL_WRAP_EN
    head_d  = head_q;
    if (push) begin
      mem_d[wr_idx] = din;
      head_d        = head_inc;
      if (!full) depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      head_d  = head_dec;
      depth_d = depth_q - DW'(1);
    end
`else
    if (push && !full) begin
      mem_d[wr_idx] = din;
      depth_d       = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
`endif
  end

  // State registers; reset clears the whole trail.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      depth_q <= '0;
`ifdef TRAIL_WRAP_EN
      head_q  <= '0;
`endif
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
`ifdef TRAIL_WRAP_EN
      head_q  <= head_d;
`endif
    end
  end

  assign top   = mem_q[rd_idx];
  assign depth = depth_q;
  assign full  = (depth_q == DW'(S));
  assign empty = (depth_q == '0);

endmodule

// File: rtl/move_trail_rewinder.sv
// Records outbound ant moves and, on return_req, replays them newest-first as
// inverse moves so the ant walks home. Optional macro TRAIL_WRAP_EN keeps only
// the newest S moves instead of back-pressuring when the trail is full.
module move_trail_rewinder
  import ant_move_pkg::*;
#(
  parameter int W  = MOVE_W,
  parameter int S  = 32,
  parameter int DW = $clog2(S) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  move_in,
  input  logic          move_in_valid,
  output logic          move_in_ready,
  input  logic          return_req,
  output logic [W-1:0]  move_out,
  output logic          move_out_valid,
  input  logic          move_out_ready,
  output logic          home,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          rewinding,
  output logic          overflow
);

`ifdef TRAIL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  trail_state_e state_q, state_d;
  logic         overflow_q, overflow_d;
  logic         push, pop;
  logic [W-1:0] top_move;

  move_lifo #(.W(W), .S(S), .DW(DW)) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (move_in),
    .top   (top_move),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // FSM next-state, handshakes and sticky overflow.
  always_comb begin
    state_d        = state_q;
    overflow_d     = overflow_q;
    move_in_ready  = 1'b0;
    move_out_valid = 1'b0;
    home           = 1'b0;
    rewinding      = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    unique case (state_q)
      RECORD: begin
        move_in_ready = WRAP ? 1'b1 : !full;
        push          = move_in_valid && move_in_ready;
        // Non-wrap: a refused push while full; wrap: every overwrite.
        if (WRAP ? (push && full) : (move_in_valid && full)) overflow_d = 1'b1;
        // A move pushed in the same cycle is part of the rewind.
        if (return_req) state_d = (empty && !push) ? DONE : RETURN;
      end
      RETURN: begin
        rewinding      = 1'b1;
        move_out_valid = !empty;
        pop            = move_out_valid && move_out_ready;
        if (empty || (pop && depth == DW'(1))) state_d = DONE;
      end
      DONE: begin
        home    = 1'b1;
        state_d = RECORD;
      end
      default: state_d = RECORD;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RECORD;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign move_out = move_out_valid ? W'(inv_move(MOVE_W'(top_move))) : W'(MOVE_N);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_move_trail_rewinder.sv
// Self-checking bench for move_trail_rewinder: model trail queue, scoreboard of
// expected inverse moves filled at return_req and drained on each handshake.
module tb_move_trail_rewinder;

  localparam int W  = 3;
  localparam int S  = 32;
  localparam int DW = $clog2(S) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  move_in;
  logic          move_in_valid;
  logic          move_in_ready;
  logic          return_req;
  logic [W-1:0]  move_out;
  logic          move_out_valid;
  logic          move_out_ready;
  logic          home;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          rewinding;
  logic          overflow;

  move_trail_rewinder #(.W(W), .S(S), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .move_in        (move_in),
    .move_in_valid  (move_in_valid),
    .move_in_ready  (move_in_ready),
    .return_req     (return_req),
    .move_out       (move_out),
    .move_out_valid (move_out_valid),
    .move_out_ready (move_out_ready),
    .home           (home),
    .depth          (depth),
    .full           (full),
    .empty          (empty),
    .rewinding      (rewinding),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sb[$];
  int trail[$];
  bit exp_ovf;
  int hs_cnt, home_cnt, vld_cnt, last_hs_cyc, first_hs_cyc, home_cyc, ret_cyc;

  function automatic int inv(int m);
    return (m + 4) % 8;
  endfunction

  task automatic clear_mon();
    hs_cnt = 0; home_cnt = 0; vld_cnt = 0;
    last_hs_cyc = -1; first_hs_cyc = -1; home_cyc = -1;
  endtask

  // Sample outputs mid-cycle, score handshakes, then advance one clock.
  task automatic step();
    int e;
    #2;
    if (move_out_valid && move_out_ready) begin
      hs_cnt++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_extra: got move_out=%0d, want no output", move_out);
      end else begin
        e = sb.pop_front();
        if (move_out !== W'(e)) begin
          bad++;
          $display("FAIL move_out: got %0d want %0d (cycle %0d)", move_out, e, cyc);
        end
      end
    end
    if (move_out_valid) vld_cnt++;
    if (home) begin home_cnt++; home_cyc = cyc; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic model_push(int m);
    if (trail.size() < S) trail.push_back(m);
    else begin
      exp_ovf = 1'b1;
`ifdef TRAIL_WRAP_EN
      void'(trail.pop_front());
      trail.push_back(m);
`endif
    end
  endtask

  task automatic push_move(int m);
    move_in = W'(m); move_in_valid = 1'b1;
    model_push(m);
    step();
    move_in_valid = 1'b0;
  endtask

  // Issue return_req (optionally with a same-cycle push) and load the scoreboard.
  task automatic start_return(bit with_push, int m);
    if (with_push) begin
      move_in = W'(m); move_in_valid = 1'b1;
      model_push(m);
    end
    for (int i = trail.size() - 1; i >= 0; i--) sb.push_back(inv(trail[i]));
    trail.delete();
    return_req = 1'b1;
    ret_cyc = cyc;
    step();
    return_req = 1'b0; move_in_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int h0;
    h0 = home_cnt;
    move_out_ready = 1'b1;
    for (int i = 0; i < budget && home_cnt == h0; i++) step();
    total++;
    if (home_cnt == h0) begin
      bad++;
      $display("FAIL home_timeout: got no home pulse in %0d cycles, want one", budget);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; move_in = '0; move_in_valid = 1'b0; return_req = 1'b0; move_out_ready = 1'b0;
    exp_ovf = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    total += 9;
    if (depth !== '0)           begin bad++; $display("FAIL rst_depth: got %0d want 0", depth); end
    if (empty !== 1'b1)         begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    if (full !== 1'b0)          begin bad++; $display("FAIL rst_full: got %b want 0", full); end
    if (rewinding !== 1'b0)     begin bad++; $display("FAIL rst_rewinding: got %b want 0", rewinding); end
    if (home !== 1'b0)          begin bad++; $display("FAIL rst_home: got %b want 0", home); end
    if (overflow !== 1'b0)      begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    if (move_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", move_out_valid); end
    if (move_out !== '0)        begin bad++; $display("FAIL rst_move_out: got %0d want 0", move_out); end
    if (move_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", move_in_ready); end
  endtask

  task automatic test_basic();
    clear_mon();
    push_move(2); push_move(0); push_move(5);
    total++;
    if (depth !== DW'(3)) begin bad++; $display("FAIL basic_depth: got %0d want 3", depth); end
    move_out_ready = 1'b1;
    start_return(1'b0, 0);
    drain(10);
    total += 5;
    if (hs_cnt != 3) begin bad++; $display("FAIL basic_pops: got %0d want 3", hs_cnt); end
    if (first_hs_cyc != ret_cyc + 1) begin bad++; $display("FAIL basic_first_valid: got cycle %0d want %0d", first_hs_cyc, ret_cyc + 1); end
    if (home_cyc != last_hs_cyc + 1) begin bad++; $display("FAIL basic_home_cycle: got %0d want %0d", home_cyc, last_hs_cyc + 1); end
    if (home_cnt != 1) begin bad++; $display("FAIL basic_home_count: got %0d want 1", home_cnt); end
    if (depth !== '0) begin bad++; $display("FAIL basic_depth_end: got %0d want 0", depth); end
  endtask

  task automatic test_empty_return();
    clear_mon();
    move_out_ready = 1'b1;
    start_return(1'b0, 0);
    step(); step(); step();
    total += 3;
    if (home_cnt != 1) begin bad++; $display("FAIL empty_home_count: got %0d want 1", home_cnt); end
    if (home_cyc != ret_cyc + 1) begin bad++; $display("FAIL empty_home_cycle: got %0d want %0d", home_cyc, ret_cyc + 1); end
    if (vld_cnt != 0) begin bad++; $display("FAIL empty_out_valid: got %0d valid cycles want 0", vld_cnt); end
  endtask

  task automatic test_full();
    int n;
    bit exp_rdy;
`ifdef TRAIL_WRAP_EN
    n = S + 2; exp_rdy = 1'b1;
`else
    n = S + 1; exp_rdy = 1'b0;
`endif
    clear_mon();
    move_out_ready = 1'b0;
    for (int i = 0; i < n - 1; i++) push_move(int'($urandom_range(0, 7)));
    move_in = 3'd6; move_in_valid = 1'b1;
    #1;
    total++;
    if (move_in_ready !== exp_rdy) begin bad++; $display("FAIL full_in_ready: got %b want %b", move_in_ready, exp_rdy); end
    model_push(6);
    step();
    move_in_valid = 1'b0;
    total += 3;
    if (full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", full); end
    if (overflow !== exp_ovf) begin bad++; $display("FAIL full_overflow: got %b want %b", overflow, exp_ovf); end
    if (depth !== DW'(S)) begin bad++; $display("FAIL full_depth: got %0d want %0d", depth, S); end
    move_out_ready = 1'b1;
    start_return(1'b0, 0);
    drain(S + 8);
    total += 3;
    if (hs_cnt != S) begin bad++; $display("FAIL full_pops: got %0d want %0d", hs_cnt, S); end
    if (last_hs_cyc - first_hs_cyc + 1 != S) begin bad++; $display("FAIL full_drain_cycles: got %0d want %0d", last_hs_cyc - first_hs_cyc + 1, S); end
    if (sb.size() != 0) begin bad++; $display("FAIL full_sb_left: got %0d entries want 0", sb.size()); end
  endtask

  task automatic test_stall();
    logic [W-1:0] s0, s1, s2;
    int want;
    clear_mon();
    push_move(1); push_move(2); push_move(3);
    move_out_ready = 1'b0;
    start_return(1'b0, 0);
    #1;
    total += 2;
    if (rewinding !== 1'b1) begin bad++; $display("FAIL stall_rewinding: got %b want 1", rewinding); end
    if (move_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", move_in_ready); end
    move_out_ready = 1'b1; step();
    move_out_ready = 1'b0; #1; s0 = move_out; step();
    #1; s1 = move_out; step();
    move_out_ready = 1'b1; #1; s2 = move_out; step();
    move_out_ready = 1'b0;
    want = inv(2);
    total += 5;
    if (s0 !== W'(want)) begin bad++; $display("FAIL stall_out0: got %0d want %0d", s0, want); end
    if (s1 !== W'(want)) begin bad++; $display("FAIL stall_out1: got %0d want %0d", s1, want); end
    if (s2 !== W'(want)) begin bad++; $display("FAIL stall_out2: got %0d want %0d", s2, want); end
    if (hs_cnt != 2) begin bad++; $display("FAIL stall_pops: got %0d want 2", hs_cnt); end
    if (depth !== DW'(1)) begin bad++; $display("FAIL stall_depth: got %0d want 1", depth); end
    drain(6);
  endtask

  task automatic test_same_cycle();
    clear_mon();
    push_move(0);
    move_out_ready = 1'b1;
    start_return(1'b1, 3);
    drain(8);
    total += 2;
    if (hs_cnt != 2) begin bad++; $display("FAIL same_cycle_pops: got %0d want 2", hs_cnt); end
    if (sb.size() != 0) begin bad++; $display("FAIL same_cycle_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_rst_mid();
    clear_mon();
    for (int i = 0; i < 7; i++) push_move(i);
    move_out_ready = 1'b1;
    start_return(1'b0, 0);
    step(); step();
    move_out_ready = 1'b0;
    #1;
    total++;
    if (depth !== DW'(5)) begin bad++; $display("FAIL rstmid_depth_before: got %0d want 5", depth); end
    rst = 1'b1; step(); rst = 1'b0;
    sb.delete(); trail.delete(); exp_ovf = 1'b0;
    #1;
    total += 4;
    if (depth !== '0) begin bad++; $display("FAIL rstmid_depth: got %0d want 0", depth); end
    if (rewinding !== 1'b0) begin bad++; $display("FAIL rstmid_rewinding: got %b want 0", rewinding); end
    if (move_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", move_in_ready); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    step(); step(); step();
    total++;
    if (home_cnt != 0) begin bad++; $display("FAIL rstmid_home: got %0d pulses want 0", home_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_return();
    test_full();
    test_stall();
    test_same_cycle();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
